imem_reader: RTL and testbench
==============================

// Module: imem_reader
// PURPOSE
//  Read-side controller for the input memory block (9-bit words, 60 entries, one word per access).
//  On a start pulse it sweeps addresses 0..LEN-1 through the memory read port (rd/oaddr/odata),
//  absorbs the 1-cycle memory read latency and streams words to the affine datapath over valid/ready.
//  Sits between imem and the datapath; the host writes imem first, then pulses start.
// PARAMETERS
//  DATA_W  9   word width, matches imem data port
//  ADDR_W  6   address width, matches imem address port
//  DEPTH   60  number of valid entries in imem
// PORTS
//  clock      in   1       single clock; all state updates on posedge
//  reset_n    in   1       asynchronous, active-low reset
//  start      in   1       1-cycle pulse: begin sweep; ignored while busy
//  mem_wr     in   1       imem write strobe (monitored); imem gives wr priority over rd
//  mem_rd     out  1       imem read strobe
//  mem_addr   out  ADDR_W  imem read address (oaddr)
//  mem_data   in   DATA_W  imem read data, valid the cycle after mem_rd
//  out_data   out  DATA_W  word to datapath
//  out_valid  out  1       out_data valid
//  out_ready  in   1       datapath accepts when out_valid & out_ready
//  out_last   out  1       high with final word of sweep
//  busy       out  1       sweep in progress (start accepted, done not yet pulsed)
//  done       out  1       1-cycle pulse after final word accepted
// BEHAVIOUR
//  Reset (async, reset_n=0): FSM=IDLE; mem_rd, out_valid, out_last, busy, done = 0; mem_addr = 0; buffer emptied.
//  FSM: IDLE -start-> READ (issue_cnt=0, sent_cnt=0); READ -all LEN reads issued-> DRAIN;
//   DRAIN -final word accepted-> IDLE with done=1 for exactly one cycle. busy=1 in READ/DRAIN.
//  Issue rule: mem_rd=1 with mem_addr=issue_cnt iff state=READ, mem_wr=0, and
//   (words in-flight + words buffered) < 2 after this cycle's accept. issue_cnt++ on each issue.
//  mem_wr=1 blocks issue that cycle (read would be lost); no address skipped, sweep resumes after.
//  Capture: word read at cycle t is pushed into 2-entry output buffer at t+1; never dropped.
//  Throughput: 1 word/cycle while out_ready=1; first out_valid 2 cycles after start (start@t0 -> rd@t1 -> valid@t2).
//  Back-pressure: out_ready=0 holds out_data/out_valid/out_last stable; issue stops once buffer+in-flight=2.
//  Order: words emitted strictly in address order 0..LEN-1; out_last=1 only on word LEN-1.
//  start while busy: ignored, no effect on counters. start in same cycle as done: accepted (new sweep).
//  Counters never exceed LEN; mem_addr held at last issued value when not reading.
//  reset_n asserted mid-sweep: immediate abort, buffered words discarded, no done pulse.
// CONFIGURATION
//  IMEM_READER_LEN_EN defined: adds input `len` [ADDR_W-1:0], sampled on accepted start;
//   LEN=len, legal 1..DEPTH; len=0 or len>DEPTH clamps to DEPTH.
//  Not defined: no `len` port; LEN=DEPTH fixed.
// STRUCTURE
//  Shared package afsyn_pkg: DATA_W/ADDR_W/DEPTH constants, word_t/addr_t typedefs, FSM state enum
//   (ST_IDLE, ST_READ, ST_DRAIN).
//  One sub-module: imem_rd_skid -- 2-entry FIFO (data+last) with push, valid/ready pop, count output;
//   top level holds FSM, issue/sent counters and credit check.
// TESTING
//  1 Fill imem with addr*3; start, out_ready=1 -> 60 words 0,3,..,177 on consecutive cycles, out_last on 60th, done 1 cycle later.
//  2 out_ready toggled 1/0 every cycle -> same 60 values in order, none duplicated, out_data stable while stalled.
//  3 out_ready=0 for 20 cycles after start -> at most 2 reads issued, out_valid held with word 0; release -> full sequence.
//  4 mem_wr=1 for cycles 5-7 of sweep -> mem_rd=0 those cycles, sequence still complete and ordered.
//  5 start pulsed again mid-sweep -> ignored; reset_n=0 at word 30 -> all outputs 0 next edge, no done; fresh start works.
//  6 With IMEM_READER_LEN_EN: len=5 -> words 0..4, out_last on addr 4; len=0 -> 60 words.

Source files
------------

// File: rtl/afsyn_pkg.sv
// Shared constants, types and FSM encoding for the input-memory read path.
package afsyn_pkg;
  localparam int DATA_W = 9;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 60;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  // Out-of-range sweep lengths fall back to the full memory.
  function automatic addr_t clamp_len(input addr_t l);
    return (l == '0 || l > addr_t'(DEPTH)) ? addr_t'(DEPTH) : l;
  endfunction
endpackage

// File: rtl/imem_rd_skid.sv
// Two-entry fall-through FIFO (data + last flag) between the imem read port and the datapath.
// An empty FIFO forwards the pushed word in the same cycle, so memory data reaches out_data without an extra register.
module imem_rd_skid
  import afsyn_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [DATA_W-1:0] push_data,
  input  logic         push_last,
  output logic [DATA_W-1:0] out_data,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   count
);

  word_t      data_q [2];
  logic       last_q [2];
  logic [1:0] count_q;
  logic [1:0] keep;
  logic       pop;
  logic       store;

  assign out_valid = (count_q != 2'd0) | push;
  assign out_data  = (count_q != 2'd0) ? data_q[0] : push_data;
  assign out_last  = (count_q != 2'd0) ? last_q[0] : push_last;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    keep  = count_q;
    store = push;
    if (pop) begin
      if (count_q == 2'd0) begin
        keep  = 2'd0;
        store = 1'b0;
      end else begin
        keep = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (pop && count_q != 2'd0) begin
        data_q[0] <= data_q[1];
        last_q[0] <= last_q[1];
      end
      // Write lands after the shift so it wins when both target slot 0.
      if (store) begin
        data_q[keep[0]] <= push_data;
        last_q[keep[0]] <= push_last;
      end
      count_q <= keep + {1'b0, store};
    end
  end

endmodule

// File: rtl/imem_reader.sv
// Sweeps imem addresses 0..LEN-1 on start and streams the words to the datapath over valid/ready.
// Optional IMEM_READER_LEN_EN adds a run-time sweep length input sampled on start.
//
// state    | meaning
// ST_IDLE  | waiting for start; done pulses here for one cycle after a sweep
// ST_READ  | issuing reads while credits allow
// ST_DRAIN | all reads issued; waiting for the final word to be accepted
module imem_reader
  import afsyn_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
`ifdef IMEM_READER_LEN_EN
  input  logic [ADDR_W-1:0] len,
`endif
  input  logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t     state_q, state_d;
  addr_t      issue_cnt_q, sent_cnt_q, last_addr_q;
  addr_t      len_eff, len_m1;
  logic       rd_q, rd_last_q, done_q;
  logic [1:0] fifo_cnt;
  logic [2:0] occ;
  logic       accept, issue, start_ok, final_accept;

`ifdef IMEM_READER_LEN_EN
  addr_t len_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     len_q <= addr_t'(DEPTH);
    else if (start_ok) len_q <= clamp_len(len);
  end
  assign len_eff = len_q;
`else
  assign len_eff = addr_t'(DEPTH);
`endif

  assign len_m1       = len_eff - addr_t'(1);
  assign accept       = out_valid & out_ready;
  assign start_ok     = start & (state_q == ST_IDLE);
  // Credits: buffered words plus the word now arriving, less this cycle's pop.
  assign occ          = {1'b0, fifo_cnt} + {2'b0, rd_q} - {2'b0, accept};
  assign issue        = (state_q == ST_READ) && !mem_wr && (occ < 3'd2) && (issue_cnt_q < len_eff);
  assign final_accept = (state_q == ST_DRAIN) && accept && (sent_cnt_q == len_m1);

  always_comb begin
    state_d  = state_q;
    mem_rd   = issue;
    mem_addr = issue ? issue_cnt_q : last_addr_q;
    busy     = (state_q != ST_IDLE);
    done     = done_q;
    case (state_q)
      ST_IDLE:  if (start)                               state_d = ST_READ;
      ST_READ:  if (issue && issue_cnt_q == len_m1)      state_d = ST_DRAIN;
      ST_DRAIN: if (final_accept)                        state_d = ST_IDLE;
      default:                                           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      sent_cnt_q  <= '0;
      last_addr_q <= '0;
      rd_q        <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= issue;
      rd_last_q <= issue && (issue_cnt_q == len_m1);
      done_q    <= final_accept;
      if (issue) last_addr_q <= issue_cnt_q;
      if (start_ok) begin
        issue_cnt_q <= '0;
        sent_cnt_q  <= '0;
      end else begin
        if (issue)  issue_cnt_q <= issue_cnt_q + addr_t'(1);
        if (accept) sent_cnt_q  <= sent_cnt_q + addr_t'(1);
      end
    end
  end

  imem_rd_skid u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_q),
    .push_data (mem_data),
    .push_last (rd_last_q),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_imem_reader.sv
// Directed bench for imem_reader: models imem (word = addr*3, 1-cycle read latency) and checks each scenario inline.
module tb_imem_reader;
  localparam int LEN = 60;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       mem_wr = 1'b0;
  logic       mem_rd;
  logic [5:0] mem_addr;
  logic [8:0] mem_data = '0;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       busy;
  logic       done;
`ifdef IMEM_READER_LEN_EN
  logic [5:0] len = '0;
`endif

  int checks = 0;
  int failures = 0;
  logic [8:0] mem [64];

  always #5 clock = ~clock;

  always @(posedge clock)
    if (mem_rd && !mem_wr) mem_data <= mem[mem_addr];

  imem_reader dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
`ifdef IMEM_READER_LEN_EN
    .len       (len),
`endif
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Pulse start for one cycle; leaves the bench #1 into the first READ cycle.
  task automatic kick();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; mem_wr = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({mem_rd, out_valid, out_last, busy, done} !== 5'b0 || mem_addr !== 6'd0) begin
      failures++;
      $display("FAIL reset_outputs got rd=%b v=%b l=%b busy=%b done=%b addr=%0d want all 0",
               mem_rd, out_valid, out_last, busy, done, mem_addr);
    end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_stream();
    int idx = 0, c_last = -1, c_done = -1;
    out_ready = 1'b1;
    kick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 6'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL stream_first_rd got rd=%b addr=%0d busy=%b want 1 0 1", mem_rd, mem_addr, busy);
    end
    for (int c = 0; c < 200 && c_done < 0; c++) begin
      @(negedge clock); #1;
      if (done) c_done = c;
      else if (idx < LEN) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 9'(idx*3) || out_last !== (idx == LEN-1)) begin
          failures++; $display("FAIL stream_word%0d got v=%b d=%0d l=%b want 1 %0d %b", idx, out_valid, out_data, out_last, idx*3, idx == LEN-1);
        end
        if (out_valid) begin c_last = c; idx++; end
      end
    end
    checks++;
    if (idx != LEN || c_last != LEN-1 || c_done != LEN) begin
      failures++; $display("FAIL stream_done got words=%0d last_cyc=%0d done_cyc=%0d want %0d %0d %0d", idx, c_last, c_done, LEN, LEN-1, LEN);
    end
    @(negedge clock); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL stream_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_toggle_ready();
    int idx = 0;
    bit seen_done = 0, stalled = 0;
    logic [8:0] held = '0;
    out_ready = 1'b0;
    kick();
    for (int c = 0; c < 400 && !seen_done; c++) begin
      @(negedge clock); out_ready = (c % 2 == 0); #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          failures++; $display("FAIL toggle_hold got v=%b d=%0d want 1 %0d", out_valid, out_data, held);
        end
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      if (done) seen_done = 1;
      else if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 9'(idx*3) || out_last !== (idx == LEN-1)) begin
          failures++; $display("FAIL toggle_word%0d got d=%0d l=%b want %0d %b", idx, out_data, out_last, idx*3, idx == LEN-1);
        end
        idx++;
      end
    end
    checks++;
    if (!seen_done || idx != LEN) begin
      failures++; $display("FAIL toggle_count got words=%0d done=%b want %0d 1", idx, seen_done, LEN);
    end
    out_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    int idx = 0, rds = 0;
    bit seen_done = 0;
    out_ready = 1'b0;
    kick();
    if (mem_rd) rds++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); #1;
      if (mem_rd) rds++;
    end
    checks++;
    if (rds > 2 || out_valid !== 1'b1 || out_data !== 9'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL bp_hold got reads=%0d v=%b d=%0d busy=%b want <=2 1 0 1", rds, out_valid, out_data, busy);
    end
    for (int c = 0; c < 200 && !seen_done; c++) begin
      @(negedge clock); out_ready = 1'b1; #1;
      if (done) seen_done = 1;
      else if (out_valid) begin
        checks++;
        if (out_data !== 9'(idx*3) || out_last !== (idx == LEN-1)) begin
          failures++; $display("FAIL bp_word%0d got d=%0d l=%b want %0d %b", idx, out_data, out_last, idx*3, idx == LEN-1);
        end
        idx++;
      end
    end
    checks++;
    if (!seen_done || idx != LEN) begin
      failures++; $display("FAIL bp_count got words=%0d done=%b want %0d 1", idx, seen_done, LEN);
    end
    @(negedge clock);
  endtask

  task automatic test_mem_wr_block();
    int idx = 0, rd_idx = 0;
    bit seen_done = 0;
    out_ready = 1'b1;
    kick();
    if (mem_rd) begin
      checks++;
      if (mem_addr !== 6'd0) begin failures++; $display("FAIL wr_addr0 got %0d want 0", mem_addr); end
      rd_idx++;
    end
    for (int c = 0; c < 200 && !seen_done; c++) begin
      @(negedge clock); mem_wr = (c >= 3 && c <= 5); #1;
      if (mem_wr) begin
        checks++;
        if (mem_rd !== 1'b0) begin failures++; $display("FAIL wr_block_cyc%0d got rd=%b want 0", c + 2, mem_rd); end
      end
      if (mem_rd) begin
        checks++;
        if (mem_addr !== 6'(rd_idx)) begin failures++; $display("FAIL wr_addr%0d got %0d want %0d", rd_idx, mem_addr, rd_idx); end
        rd_idx++;
      end
      if (done) seen_done = 1;
      else if (out_valid) begin
        checks++;
        if (out_data !== 9'(idx*3) || out_last !== (idx == LEN-1)) begin
          failures++; $display("FAIL wr_word%0d got d=%0d l=%b want %0d %b", idx, out_data, out_last, idx*3, idx == LEN-1);
        end
        idx++;
      end
    end
    mem_wr = 1'b0;
    checks++;
    if (!seen_done || idx != LEN || rd_idx != LEN) begin
      failures++; $display("FAIL wr_count got words=%0d reads=%0d done=%b want %0d %0d 1", idx, rd_idx, seen_done, LEN, LEN);
    end
    @(negedge clock);
  endtask

  task automatic test_restart_and_abort();
    int idx = 0;
    bit seen_done = 0, bad_done = 0;
    out_ready = 1'b1;
    kick();
    for (int c = 0; c < 100 && idx <= 30; c++) begin
      @(negedge clock); start = (c == 10); #1;
      if (done) bad_done = 1;
      if (out_valid) begin
        checks++;
        if (out_data !== 9'(idx*3) || busy !== 1'b1) begin
          failures++; $display("FAIL busy_start_word%0d got d=%0d busy=%b want %0d 1", idx, out_data, busy, idx*3);
        end
        idx++;
      end
    end
    start = 1'b0;
    @(negedge clock); reset_n = 1'b0; #1;
    checks++;
    if ({mem_rd, out_valid, out_last, busy, done} !== 5'b0) begin
      failures++; $display("FAIL abort_outputs got rd=%b v=%b l=%b busy=%b done=%b want all 0", mem_rd, out_valid, out_last, busy, done);
    end
    repeat (2) begin @(negedge clock); #1; if (done) bad_done = 1; end
    reset_n = 1'b1;
    repeat (2) begin @(negedge clock); #1; if (done) bad_done = 1; end
    checks++;
    if (bad_done) begin failures++; $display("FAIL abort_no_done got done pulse want none"); end
    idx = 0;
    kick();
    for (int c = 0; c < 200 && !seen_done; c++) begin
      @(negedge clock); #1;
      if (done) seen_done = 1;
      else if (out_valid) begin
        checks++;
        if (out_data !== 9'(idx*3) || out_last !== (idx == LEN-1)) begin
          failures++; $display("FAIL fresh_word%0d got d=%0d l=%b want %0d %b", idx, out_data, out_last, idx*3, idx == LEN-1);
        end
        idx++;
      end
    end
    checks++;
    if (!seen_done || idx != LEN) begin
      failures++; $display("FAIL fresh_count got words=%0d done=%b want %0d 1", idx, seen_done, LEN);
    end
    @(negedge clock);
  endtask

`ifdef IMEM_READER_LEN_EN
  task automatic test_len();
    int exp_len [3] = '{5, 60, 60};
    logic [5:0] req [3] = '{6'd5, 6'd0, 6'd63};
    for (int t = 0; t < 3; t++) begin
      int idx = 0;
      bit seen_done = 0;
      out_ready = 1'b1;
      len = req[t];
      kick();
      len = 6'd1;
      for (int c = 0; c < 200 && !seen_done; c++) begin
        @(negedge clock); #1;
        if (done) seen_done = 1;
        else if (out_valid) begin
          checks++;
          if (out_data !== 9'(idx*3) || out_last !== (idx == exp_len[t]-1)) begin
            failures++; $display("FAIL len%0d_word%0d got d=%0d l=%b want %0d %b", req[t], idx, out_data, out_last, idx*3, idx == exp_len[t]-1);
          end
          idx++;
        end
      end
      checks++;
      if (!seen_done || idx != exp_len[t]) begin
        failures++; $display("FAIL len%0d_count got words=%0d done=%b want %0d 1", req[t], idx, seen_done, exp_len[t]);
      end
      @(negedge clock);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = (i < LEN) ? 9'(i*3) : 9'h1AA;
    test_reset();
    test_stream();
    test_toggle_ready();
    test_backpressure();
    test_mem_wr_block();
    test_restart_and_abort();
`ifdef IMEM_READER_LEN_EN
    test_len();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
